cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Requester-side engine for one cache (I or D) talking to ram_controller.
//  On a miss, fetches an 8-word (16-byte) block one word at a time via the
//  level-held read request/data_valid handshake, writes each returned word
//  into the cache data array, and writes the tag with the last word. One
//  instance per cache; stalls the pipeline through fsm_busy while filling.
// PARAMETERS
//  ADDR_W   16  byte-address width
//  DATA_W   16  word width
//  WORDS    8   words per block (power of two); offset bits = log2(WORDS)+1
// PORTS
//  clk                 in   1       clock, all state on rising edge
//  rst                 in   1       asynchronous, active-high reset
//  miss_detected       in   1       cache lookup missed this cycle
//  miss_address        in   ADDR_W  byte address of the missing access
//  fsm_busy            out  1       fill in progress or starting; stalls pipeline
//  write_data_array    out  1       write cache_write_data at cache_word_address
//  write_tag_array     out  1       write tag/valid for block of cache_word_address
//  cache_word_address  out  ADDR_W  byte address of word being written to cache
//  cache_write_data    out  DATA_W  word to write into cache (= mem_data_in)
//  mem_read_req        out  1       to ram_controller x_cache_miss input
//  mem_read_address    out  ADDR_W  to ram_controller x_cache_miss_address
//  mem_data_valid      in   1       from ram_controller x_cache_data_valid
//  mem_data_in         in   DATA_W  from ram_controller ram_data_out
// BEHAVIOUR
//  States: IDLE=0, FILL=1 (1-bit state reg). Registers: state, base[ADDR_W-1:4],
//   word count cnt[2:0]. Async rst -> state=IDLE, cnt=0, base=0 immediately.
//  IDLE: miss_detected -> capture base=miss_address[15:4], cnt=0, go FILL next
//   cycle. mem_data_valid in IDLE ignored (no writes).
//  FILL: mem_read_req=1, held level; mem_read_address={base,cnt,1'b0}, stable
//   until the cycle after mem_data_valid. Controller may delay grant
//   (writes/other cache have priority): engine waits indefinitely.
//  On mem_data_valid in FILL: write_data_array=1 same cycle,
//   cache_word_address={base,cnt,1'b0}, cache_write_data=mem_data_in
//   (combinational); cnt<=cnt+1. If cnt==WORDS-1: write_tag_array=1 same cycle,
//   mem_read_req still 1 that cycle, state<=IDLE, cnt wraps to 0.
//  miss_detected / miss_address changes during FILL ignored; no restart.
//  fsm_busy = (state==FILL) | (state==IDLE & miss_detected); low the cycle
//   after the last word. write_*_array, mem_read_req are 0 outside FILL.
//  Reset values: mem_read_req=0, write_data_array=0, write_tag_array=0,
//   mem_read_address=0, cache_word_address=0; fsm_busy=miss_detected.
//  Reset mid-fill: abort instantly; tag never written so partial block stays
//   invalid; next miss restarts at word 0.
//  Address arithmetic: offset bits forced from cnt, never added to base; no
//   carry; miss 0xFFFF -> words 0xFFF0..0xFFFE.
//  Latency per word = controller arbitration (>=1) + 4-cycle memory; block
//   fill >= 8*5 cycles with uncontended memory.
// STRUCTURE
//  Shared header cache_defines.vh: WORDS, offset width, state encodings
//   (FILL_IDLE, FILL_ACTIVE), reused by both caches and ram_controller bench.
//  Sub-module fill_counter: 3-bit counter of dff cells with wen=inc and
//   async clear; state/base registers use dff arrays as elsewhere.
// TESTING
//  Miss 0x1234, valid 4 cycles after each req -> reads 0x1230,0x1232..0x123E
//   in order; 8 write_data_array pulses; tag pulse with 8th; busy low next cycle.
//  Grant delayed 10 cycles per word (ram_write contention) -> address held,
//   no writes until valid; same 8 words, same order.
//  rst high after 3rd word -> req/writes 0 same cycle, no tag write; new miss
//   0x0040 -> restarts at 0x0040.
//  Miss 0xFFFF -> base 0xFFF0, last word 0xFFFE, no wrap to 0x0000.
//  mem_data_valid pulsed in IDLE -> no writes; miss_detected toggled and
//   miss_address changed during FILL -> fill of original block completes.
//  miss_detected again the cycle after completion -> one IDLE cycle, new fill.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill engine.
//  FILL_WORDS   default words per block (power of two)
//  FILL_IDLE    state encoding: waiting for a miss
//  FILL_ACTIVE  state encoding: fetching words from the RAM controller
//  offset_width byte-offset bits of a block: log2(words) word bits + 1 byte bit
package cache_fill_fsm_pkg;

    localparam int unsigned FILL_WORDS = 8;

    localparam logic FILL_IDLE   = 1'b0;
    localparam logic FILL_ACTIVE = 1'b1;

    function automatic int unsigned offset_width(input int unsigned words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill.
//  clk    in   clock
//  rst    in   asynchronous active-high clear
//  clr    in   synchronous clear (new fill starting)
//  inc    in   advance to the next word
//  count  out  current word index; wraps to 0 after the last word
module cache_fill_fsm_fill_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Requester-side block fill engine for one cache. On a miss it fetches a whole
// block one word at a time from the RAM controller using a level-held read
// request, writes each returned word into the data array and writes the tag
// together with the final word.
//  clk                 in   clock
//  rst                 in   asynchronous active-high reset
//  miss_detected       in   cache lookup missed this cycle
//  miss_address        in   byte address of the missing access
//  fsm_busy            out  fill running or about to start; stalls the pipeline
//  write_data_array    out  write cache_write_data at cache_word_address
//  write_tag_array     out  write tag/valid for the block of cache_word_address
//  cache_word_address  out  byte address of the word being written
//  cache_write_data    out  word to write (passthrough of mem_data_in)
//  mem_read_req        out  read request to the RAM controller (level held)
//  mem_read_address    out  byte address being requested
//  mem_data_valid      in   requested word is on mem_data_in this cycle
//  mem_data_in         in   read data from the RAM controller
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = FILL_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_word_address,
    output logic [DATA_W-1:0] cache_write_data,
    output logic              mem_read_req,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam int unsigned OFF_W = offset_width(WORDS);

    logic                    state_q, state_d;
    logic [ADDR_W-1:OFF_W]   base_q, base_d;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    last_word;
    logic [ADDR_W-1:0]       word_addr;
    logic                    unused_miss_offset;

    cache_fill_fsm_fill_counter #(
        .WIDTH (CNT_W)
    ) u_fill_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    // Offset bits come straight from the counter, so a fill never carries into
    // the block base even for the topmost block of the address space.
    assign word_addr = {base_q, cnt, 1'b0};
    assign last_word = (cnt == CNT_W'(WORDS - 1));

    // Byte offset of the missing access is irrelevant: the whole block is fetched.
    assign unused_miss_offset = ^miss_address[OFF_W-1:0];

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        mem_read_req     = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                if (miss_detected) begin
                    base_d  = miss_address[ADDR_W-1:OFF_W];
                    cnt_clr = 1'b1;
                    state_d = FILL_ACTIVE;
                end
            end
            FILL_ACTIVE: begin
                mem_read_req = 1'b1;
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    cnt_inc          = 1'b1;
                    if (last_word) begin
                        // Tag goes in with the final word so a partial block never looks valid.
                        write_tag_array = 1'b1;
                        state_d         = FILL_IDLE;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    assign fsm_busy           = (state_q == FILL_ACTIVE) | ((state_q == FILL_IDLE) & miss_detected);
    assign mem_read_address   = word_addr;
    assign cache_word_address = word_addr;
    assign cache_write_data   = mem_data_in;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_word_address;
    logic [15:0] cache_write_data;
    logic        mem_read_req;
    logic [15:0] mem_read_address;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .ADDR_W (16),
        .DATA_W (16),
        .WORDS  (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .miss_detected      (miss_detected),
        .miss_address       (miss_address),
        .fsm_busy           (fsm_busy),
        .write_data_array   (write_data_array),
        .write_tag_array    (write_tag_array),
        .cache_word_address (cache_word_address),
        .cache_write_data   (cache_write_data),
        .mem_read_req       (mem_read_req),
        .mem_read_address   (mem_read_address),
        .mem_data_valid     (mem_data_valid),
        .mem_data_in        (mem_data_in)
    );

    // Acts as the RAM controller for one block fill. Expected cache writes are
    // queued when the miss is raised and popped as write pulses appear.
    // abort_after >= 0: assert rst right after that many words have returned.
    task automatic do_fill(input logic [15:0] addr, input int dly, input bit disturb,
                           input int abort_after);
        logic [15:0] wdata [8];
        logic [15:0] exp_addr;
        exp_t        e;
        int          nw;
        nw = (abort_after >= 0) ? abort_after : 8;
        @(posedge clk); #1;
        mem_data_valid = 1'b0;
        miss_detected  = 1'b1;
        miss_address   = addr;
        for (int w = 0; w < 8; w++) begin
            wdata[w] = 16'($urandom);
            e.addr   = {addr[15:4], 3'(w), 1'b0};
            e.data   = wdata[w];
            e.tag    = (w == 7);
            sb.push_back(e);
        end
        @(negedge clk);
        n_cmp++;
        if (fsm_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL miss_busy: fsm_busy=%b required 1", fsm_busy);
        end
        n_cmp++;
        if (mem_read_req !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_req: mem_read_req=%b required 0", mem_read_req);
        end
        for (int w = 0; w < nw; w++) begin
            exp_addr = {addr[15:4], 3'(w), 1'b0};
            for (int d = 0; d < dly; d++) begin
                @(posedge clk); #1;
                mem_data_valid = 1'b0;
                if (disturb) begin
                    miss_detected = 1'($urandom_range(0, 1));
                    miss_address  = 16'($urandom);
                end else begin
                    miss_detected = 1'b0;
                end
                @(negedge clk);
                n_cmp++;
                if (mem_read_req !== 1'b1 || fsm_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wait_req w%0d: req=%b busy=%b required 1/1", w, mem_read_req,
                             fsm_busy);
                end
                n_cmp++;
                if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wait_write w%0d: wd=%b wt=%b required 0/0", w,
                             write_data_array, write_tag_array);
                end
                n_cmp++;
                if (mem_read_address !== exp_addr) begin
                    n_bad++;
                    $display("FAIL wait_addr w%0d: addr=%h required %h", w, mem_read_address,
                             exp_addr);
                end
            end
            @(posedge clk); #1;
            mem_data_valid = 1'b1;
            mem_data_in    = wdata[w];
            if (disturb) begin
                miss_detected = 1'($urandom_range(0, 1));
                miss_address  = 16'($urandom);
            end else begin
                miss_detected = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty w%0d: no expected write queued", w);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            n_cmp++;
            if (write_data_array !== 1'b1 || mem_read_req !== 1'b1) begin
                n_bad++;
                $display("FAIL data_write w%0d: wd=%b req=%b required 1/1", w, write_data_array,
                         mem_read_req);
            end
            n_cmp++;
            if (cache_word_address !== e.addr || cache_write_data !== e.data) begin
                n_bad++;
                $display("FAIL data_word w%0d: addr=%h data=%h required %h %h", w,
                         cache_word_address, cache_write_data, e.addr, e.data);
            end
            n_cmp++;
            if (write_tag_array !== e.tag) begin
                n_bad++;
                $display("FAIL tag_write w%0d: wt=%b required %b", w, write_tag_array, e.tag);
            end
        end
        if (abort_after >= 0) begin
            @(posedge clk); #1;
            rst            = 1'b1;
            mem_data_valid = 1'b1;
            mem_data_in    = 16'hDEAD;
            miss_detected  = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (mem_read_req !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0
                || fsm_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_ctrl: req=%b wd=%b wt=%b busy=%b required 0/0/0/0",
                         mem_read_req, write_data_array, write_tag_array, fsm_busy);
            end
            n_cmp++;
            if (mem_read_address !== 16'h0000 || cache_word_address !== 16'h0000) begin
                n_bad++;
                $display("FAIL abort_addr: mem=%h cache=%h required 0000 0000", mem_read_address,
                         cache_word_address);
            end
            @(posedge clk); #1;
            rst            = 1'b0;
            mem_data_valid = 1'b0;
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        miss_detected  = 1'b0;
        miss_address   = 16'h0000;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        @(negedge clk);
        n_cmp++;
        if (mem_read_req !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0
            || fsm_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: req=%b wd=%b wt=%b busy=%b required 0/0/0/0",
                     mem_read_req, write_data_array, write_tag_array, fsm_busy);
        end
        n_cmp++;
        if (mem_read_address !== 16'h0000 || cache_word_address !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_addr: mem=%h cache=%h required 0000 0000", mem_read_address,
                     cache_word_address);
        end
        #1 miss_detected = 1'b1;
        #1;
        n_cmp++;
        if (fsm_busy !== 1'b1 || mem_read_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: busy=%b req=%b required 1/0", fsm_busy, mem_read_req);
        end
        miss_detected = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_end_of_fill(input string name);
        @(posedge clk); #1;
        mem_data_valid = 1'b0;
        miss_detected  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fsm_busy !== 1'b0 || mem_read_req !== 1'b0 || write_data_array !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done: busy=%b req=%b wd=%b required 0/0/0", name, fsm_busy,
                     mem_read_req, write_data_array);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover: %0d writes missing required 0", name, sb.size());
        end
    endtask

    task automatic test_basic_fill();
        do_fill(16'h1234, 4, 1'b0, -1);
        test_end_of_fill("basic");
    endtask

    task automatic test_delayed_grant();
        do_fill(16'h1234, 10, 1'b0, -1);
        test_end_of_fill("delayed");
    endtask

    task automatic test_reset_mid_fill();
        do_fill(16'h1234, 4, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (write_data_array !== 1'b0 || mem_read_req !== 1'b0 || fsm_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_abort_idle: wd=%b req=%b busy=%b required 0/0/0",
                         write_data_array, mem_read_req, fsm_busy);
            end
        end
        do_fill(16'h0040, 4, 1'b0, -1);
        test_end_of_fill("restart");
    endtask

    task automatic test_top_address();
        do_fill(16'hFFFF, 2, 1'b0, -1);
        test_end_of_fill("top");
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_data_valid = ~i[0];
            mem_data_in    = 16'($urandom);
            @(negedge clk);
            n_cmp++;
            if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || mem_read_req !== 1'b0
                || fsm_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_valid: wd=%b wt=%b req=%b busy=%b required 0/0/0/0",
                         write_data_array, write_tag_array, mem_read_req, fsm_busy);
            end
        end
        do_fill(16'h2468, 2, 1'b1, -1);
        test_end_of_fill("disturb");
    endtask

    task automatic test_back_to_back();
        do_fill(16'h1000, 1, 1'b0, -1);
        do_fill(16'h2A5C, 1, 1'b0, -1);
        test_end_of_fill("b2b");
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_delayed_grant();
        test_reset_mid_fill();
        test_top_address();
        test_idle_noise();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
